ofs_plat_prim_lfsr_arb: RTL and testbench
=========================================

# ofs_plat_prim_lfsr_arb

Randomized-priority N-way packet arbiter that shares one downstream valid/ready channel among `N_REQ` requesters. The start point for each arbitration is drawn from an internal 12-bit LFSR. A per-requester wait counter bounds starvation. Grants are held for multi-beat packets until EOP. It sits in front of shared platform channels (e.g., host-memory request ports) where fixed or round-robin priority would create pathological phase-locking between AFU engines.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `INITIAL_VALUE`, default 12'b101001101011: LFSR reset value; must be nonzero.
- `MAX_WAIT`, default 15: starvation bound in lost arbitrations; legal range 1..255.

**Ports**
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_eop`  in  N_REQ  per-requester end-of-packet flag, qualified by `req_valid`.
- `req_ready`  out  N_REQ  per-requester ready.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream ready.
- `grant_idx`  out  $clog2(N_REQ)  current owner index; drives the external data mux.
- `grant_onehot`  out  N_REQ  one-hot form of `grant_idx`; all zero when there is no grant.
- `locked`  out  1  high while mid-packet (owner fixed).
- `lfsr_value`  out  12  current LFSR state, for debug and coverage.

## Operation

- **Reset (async).** State=IDLE, `locked`=0, LFSR=`INITIAL_VALUE`, all wait counters=0. While `reset` is high, `req_ready`, `out_valid` and `grant_onehot` are forced to 0 and `grant_idx` to 0.
- **Fire.** A beat fires when `out_valid && out_ready`.
- **Handshake.**
  - `out_valid = req_valid[grant_idx]` when a grant exists.
  - `req_ready[i] = out_ready && grant_onehot[i]`.
  - `out_ready` may depend on `out_valid`. `req_ready` never depends on non-owner inputs while LOCKED.
- **IDLE state.** Selection is combinational each cycle.
  1. If any requester has `req_valid` and wait counter == `MAX_WAIT`, the lowest such index wins (starvation override).
  2. Otherwise start = `lfsr_value[7:0] % N_REQ`. Scan indices start, start+1, … with wrap modulo `N_REQ`. The first with `req_valid` wins.
  3. If no `req_valid`, there is no grant: `grant_onehot`=0 and `out_valid`=0.
- **Transitions.**
  - IDLE → LOCKED on a fire with `req_eop[owner]`=0. The owner index is registered.
  - LOCKED → IDLE on a fire with `req_eop[owner]`=1.
  - A single-beat packet (EOP on the first beat) stays in IDLE.
- **LOCKED state.** Grant is the registered owner regardless of other requests. If the owner drops `req_valid`, `out_valid`=0 and the grant is held. `locked`=1 combinationally from the state register.
- **Packet completion** (fire with `req_eop`=1, in either state):
  - The LFSR advances exactly one step.
  - The owner's wait counter clears to 0.
  - Every other requester with `req_valid`=1 in that cycle increments its counter, saturating at `MAX_WAIT`.
  - Requesters with `req_valid`=0 keep their count.
  - Counters change at no other time.
- **LFSR step** (right shift, Galois taps):
  - b11←b0
  - b10..b6 ← b11..b7
  - b5←b6^b0
  - b4←b5
  - b3←b4^b0
  - b2←b3
  - b1←b2
  - b0←b1^b0
- **Width rules.** Wait counters are $clog2(MAX_WAIT+1) bits wide. The modulo is computed on the 8-bit field; power-of-two `N_REQ` reduces to bit slicing.

## Timing

- Grant latency in IDLE: 0 cycles. A request valid in cycle t can fire in cycle t.
- Back-to-back packets from different requesters with no bubble. The next IDLE decision uses the LFSR value updated at the previous EOP edge.
- Within a packet, one beat per cycle is sustained when owner valid and `out_ready` are both continuously high.
- Simultaneous events:
  - EOP fire and a new request in the same cycle: the new request is considered at the next cycle's IDLE decision.
  - Override and random start in the same cycle: override wins.
- Reset asserted mid-packet: immediate return to IDLE and outputs forced low. After reset deasserts, the first decision uses `INITIAL_VALUE`.

## Test plan

- **Reset values.** N_REQ=4, default INITIAL_VALUE: assert reset with all req_valid=1 → `req_ready`=0, `out_valid`=0, `lfsr_value`=0xA6B. Release reset → `grant_idx`=3 (0x6B % 4).
- **Random sequence.** All four requesters valid with single-beat EOP packets, `out_ready`=1.
  - Cycle 0: grant 3.
  - Cycle 1: `lfsr_value`=0xD1C, grant 0.
  - 4095 further EOPs return `lfsr_value` to 0xA6B.
- **Packet lock.** Requester 3 sends 4 beats (EOP on beat 4) while 0..2 are valid → `grant_idx`=3 and `locked`=1 for beats 2–4, `out_ready` stalls included. The LFSR advances once, only on the beat-4 fire.
- **Owner bubble.** Requester 3 drops valid for 2 cycles mid-packet → `out_valid`=0, `grant_idx` stays 3, and no other `req_ready` rises.
- **Starvation.** MAX_WAIT=2; requester 1 continuously valid and losing → after its counter hits 2, the next IDLE decision grants 1 regardless of LFSR. Its counter then returns to 0.
- **Async reset mid-packet.** Reset during beat 2 of a 4-beat packet → `locked`=0 within the same cycle, counters=0. The first post-reset grant again uses start=3.

Source files
------------

// File: rtl/ofs_plat_prim_lfsr_arb.sv
// ofs_plat_prim_lfsr_arb
//   Randomized-priority N-way packet arbiter. The scan start point for each
//   IDLE decision comes from a 12-bit Galois LFSR. Per-requester wait counters
//   bound starvation. A multi-beat packet holds the grant until its EOP beat.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   req_valid     per-requester beat valid
//   req_eop       per-requester end-of-packet, qualified by req_valid
//   req_ready     per-requester ready (out_ready gated by grant)
//   out_valid     downstream valid
//   out_ready     downstream ready
//   grant_idx     current owner index (drives external data mux)
//   grant_onehot  one-hot form of grant_idx, zero when there is no grant
//   locked        high while mid-packet
//   lfsr_value    current LFSR state
module ofs_plat_prim_lfsr_arb #(
  parameter int unsigned N_REQ         = 4,
  parameter logic [11:0] INITIAL_VALUE = 12'b101001101011,
  parameter int unsigned MAX_WAIT      = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_eop,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic [N_REQ-1:0]           grant_onehot,
  output logic                       locked,
  output logic [11:0]                lfsr_value
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] owner;
  logic [11:0]      lfsr;
  logic [11:0]      lfsr_step;
  logic [CNT_W-1:0] wait_cnt [N_REQ];

  logic [N_REQ-1:0] starving;
  int unsigned      start_i;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] idle_sel;
  logic             has_grant;
  logic [IDX_W-1:0] gidx;
  logic             fire;
  logic             owner_eop;
  logic             pkt_done;
  logic             lock_start;

  // Right-shifting Galois step, feedback from b0 into b11, b5, b3, b0.
  assign lfsr_step = {lfsr[0], lfsr[11:7], lfsr[6] ^ lfsr[0], lfsr[5],
                      lfsr[4] ^ lfsr[0], lfsr[3], lfsr[2], lfsr[1] ^ lfsr[0]};

  always_comb begin
    starving = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      starving[i] = req_valid[i] && (wait_cnt[i] == CNT_W'(MAX_WAIT));
    end
  end

  // IDLE choice. Both scans run from the far end downwards so the last write
  // (smallest offset / lowest starving index) wins; starvation is applied
  // after the random scan so it overrides it.
  always_comb begin
    start_i  = 32'(lfsr[7:0]) % N_REQ;
    idle_sel = '0;
    scan_idx = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      scan_idx = IDX_W'((start_i + k - 1) % N_REQ);
      if (req_valid[scan_idx]) begin
        idle_sel = scan_idx;
      end
    end
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (starving[i-1]) begin
        idle_sel = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    has_grant = 1'b0;
    gidx      = '0;
    if (state == LOCKED) begin
      has_grant = 1'b1;
      gidx      = owner;
    end else begin
      has_grant = |req_valid;
      gidx      = idle_sel;
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (!reset && has_grant) begin
      grant_onehot[gidx] = 1'b1;
    end
    grant_idx  = reset ? '0 : gidx;
    out_valid  = !reset && has_grant && req_valid[gidx];
    req_ready  = out_ready ? grant_onehot : '0;
    locked     = (state == LOCKED);
    lfsr_value = lfsr;
  end

  assign fire       = out_valid && out_ready;
  assign owner_eop  = req_eop[gidx];
  assign pkt_done   = fire && owner_eop;
  assign lock_start = (state == IDLE) && fire && !owner_eop;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (lock_start) state_next = LOCKED;
      LOCKED:  if (pkt_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= '0;
    end else if (lock_start) begin
      owner <= gidx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= INITIAL_VALUE;
    end else if (pkt_done) begin
      lfsr <= lfsr_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else if (pkt_done) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (IDX_W'(i) == gidx) begin
          wait_cnt[i] <= '0;
        end else if (req_valid[i] && (wait_cnt[i] != CNT_W'(MAX_WAIT))) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ofs_plat_prim_lfsr_arb.sv
module tb_ofs_plat_prim_lfsr_arb;

  localparam int MAX_W = 2;
  localparam logic [11:0] INIT = 12'hA6B;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_eop;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_idx;
  logic [3:0]  grant_onehot;
  logic        locked;
  logic [11:0] lfsr_value;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        has;
    logic [1:0]  idx;
    logic [3:0]  oh;
    logic        ov;
    logic [3:0]  rr;
    logic        lk;
    logic [11:0] lf;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [11:0] m_lfsr;
  int          m_cnt[4];
  logic        m_locked;
  logic [1:0]  m_owner;

  ofs_plat_prim_lfsr_arb #(
    .N_REQ(4),
    .INITIAL_VALUE(INIT),
    .MAX_WAIT(MAX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_eop(req_eop),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .grant_idx(grant_idx),
    .grant_onehot(grant_onehot),
    .locked(locked),
    .lfsr_value(lfsr_value)
  );

  always #5 clk = ~clk;

  // Polynomial x^12+x^6+x^4+x+1 as a toggle mask on a right shift.
  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    return (s >> 1) ^ (s[0] ? 12'h829 : 12'h000);
  endfunction

  function automatic logic [1:0] model_pick(input logic [3:0] v);
    int unsigned start;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && m_cnt[i] == MAX_W) return 2'(i);
    end
    start = 32'(m_lfsr[7:0]) % 4;
    for (int unsigned k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return 2'((start + k) % 4);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_lfsr   = INIT;
    m_locked = 1'b0;
    m_owner  = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // One clock of stimulus: expectation pushed at drive time, popped and
  // compared at the following falling edge.
  task automatic step(input logic [3:0] v, input logic [3:0] e, input logic rdy,
                      output logic [1:0] o_idx, output logic o_ov, output logic [3:0] o_rr,
                      output logic o_lk, output logic [11:0] o_lf);
    exp_t x;
    exp_t y;
    logic [1:0] sel;
    logic f;
    @(posedge clk);
    #1;
    req_valid = v;
    req_eop   = e;
    out_ready = rdy;
    if (m_locked) begin
      x.has = 1'b1;
      sel   = m_owner;
    end else begin
      x.has = |v;
      sel   = model_pick(v);
    end
    x.idx = sel;
    x.oh  = x.has ? (4'b0001 << sel) : 4'b0000;
    x.ov  = x.has && v[sel];
    x.rr  = rdy ? x.oh : 4'b0000;
    x.lk  = m_locked;
    x.lf  = m_lfsr;
    sb.push_back(x);
    f = x.ov && rdy;
    if (f && e[sel]) begin
      m_locked = 1'b0;
      m_lfsr   = lfsr_next(m_lfsr);
      for (int i = 0; i < 4; i++) begin
        if (i == int'(sel)) m_cnt[i] = 0;
        else if (v[i] && m_cnt[i] < MAX_W) m_cnt[i]++;
      end
    end else if (f && !m_locked) begin
      m_locked = 1'b1;
      m_owner  = sel;
    end
    @(negedge clk);
    y = sb.pop_front();
    vectors++;
    if (y.has && grant_idx !== y.idx) begin
      miscompares++;
      $display("FAIL step grant_idx: got %0d expected %0d", grant_idx, y.idx);
    end
    if (grant_onehot !== y.oh) begin
      miscompares++;
      $display("FAIL step grant_onehot: got %b expected %b", grant_onehot, y.oh);
    end
    if (out_valid !== y.ov) begin
      miscompares++;
      $display("FAIL step out_valid: got %b expected %b", out_valid, y.ov);
    end
    if (req_ready !== y.rr) begin
      miscompares++;
      $display("FAIL step req_ready: got %b expected %b", req_ready, y.rr);
    end
    if (locked !== y.lk) begin
      miscompares++;
      $display("FAIL step locked: got %b expected %b", locked, y.lk);
    end
    if (lfsr_value !== y.lf) begin
      miscompares++;
      $display("FAIL step lfsr_value: got %h expected %h", lfsr_value, y.lf);
    end
    o_idx = grant_idx;
    o_ov  = out_valid;
    o_rr  = req_ready;
    o_lk  = locked;
    o_lf  = lfsr_value;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 4'hF;
    req_eop   = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || grant_onehot !== 4'b0000 ||
        grant_idx !== 2'd0 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rr=%b ov=%b oh=%b idx=%0d lk=%b expected all zero",
               req_ready, out_valid, grant_onehot, grant_idx, locked);
    end
    if (lfsr_value !== INIT) begin
      miscompares++;
      $display("FAIL reset_lfsr: got %h expected %h", lfsr_value, INIT);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if (grant_idx !== 2'd3 || out_valid !== 1'b1 || req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_grant: got idx=%0d ov=%b rr=%b expected idx=3 ov=1 rr=0000",
               grant_idx, out_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] i; logic ov; logic [3:0] rr; logic lk; logic [11:0] lf;
    step(4'hF, 4'hF, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (i !== 2'd3) begin
      miscompares++;
      $display("FAIL random_first_grant: got %0d expected 3", i);
    end
    step(4'hF, 4'hF, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (lf !== 12'hD1C || i !== 2'd0) begin
      miscompares++;
      $display("FAIL random_second: got lfsr=%h idx=%0d expected lfsr=d1c idx=0", lf, i);
    end
    for (int n = 3; n <= 4096; n++) begin
      step(4'hF, 4'hF, 1'b1, i, ov, rr, lk, lf);
    end
    vectors++;
    if (lf !== INIT) begin
      miscompares++;
      $display("FAIL random_period: got %h expected %h", lf, INIT);
    end
  endtask

  task automatic test_packet_lock();
    logic [1:0] i; logic ov; logic [3:0] rr; logic lk; logic [11:0] lf;
    logic [11:0] lf0;
    logic [3:0] vv [4];
    logic [3:0] ee [4];
    logic       rd [4];
    lf0 = m_lfsr;
    step(4'b1000, 4'b0000, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (i !== 2'd3 || rr !== 4'b1000) begin
      miscompares++;
      $display("FAIL lock_beat1: got idx=%0d rr=%b expected idx=3 rr=1000", i, rr);
    end
    vv = '{4'hF, 4'hF, 4'hF, 4'hF};
    ee = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
    rd = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int b = 0; b < 4; b++) begin
      step(vv[b], ee[b], rd[b], i, ov, rr, lk, lf);
      vectors++;
      if (i !== 2'd3 || lk !== 1'b1 || lf !== lf0) begin
        miscompares++;
        $display("FAIL lock_hold[%0d]: got idx=%0d lk=%b lfsr=%h expected idx=3 lk=1 lfsr=%h",
                 b, i, lk, lf, lf0);
      end
    end
    step(4'b0000, 4'b0000, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (lk !== 1'b0 || lf !== lfsr_next(lf0)) begin
      miscompares++;
      $display("FAIL lock_release: got lk=%b lfsr=%h expected lk=0 lfsr=%h",
               lk, lf, lfsr_next(lf0));
    end
  endtask

  task automatic test_owner_bubble();
    logic [1:0] i; logic ov; logic [3:0] rr; logic lk; logic [11:0] lf;
    step(4'b1000, 4'b0000, 1'b1, i, ov, rr, lk, lf);
    step(4'b1111, 4'b0000, 1'b1, i, ov, rr, lk, lf);
    for (int b = 0; b < 2; b++) begin
      step(4'b0111, 4'b0000, 1'b1, i, ov, rr, lk, lf);
      vectors++;
      if (ov !== 1'b0 || i !== 2'd3 || rr !== 4'b1000) begin
        miscompares++;
        $display("FAIL bubble[%0d]: got ov=%b idx=%0d rr=%b expected ov=0 idx=3 rr=1000",
                 b, ov, i, rr);
      end
    end
    step(4'b1111, 4'b1000, 1'b1, i, ov, rr, lk, lf);
    step(4'b0000, 4'b0000, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (lk !== 1'b0) begin
      miscompares++;
      $display("FAIL bubble_release: got lk=%b expected 0", lk);
    end
  endtask

  task automatic test_starvation();
    logic [1:0] i; logic ov; logic [3:0] rr; logic lk; logic [11:0] lf;
    logic [3:0] vv [4];
    logic [1:0] want [4];
    do_reset();
    // lfsr a6b/d1c/68e/347 give starts 3/0/2/3; req 1 loses twice, then
    // overrides start 2, and a cleared counter lets req 0 win the last one.
    vv   = '{4'b1010, 4'b1011, 4'b1111, 4'b0011};
    want = '{2'd3, 2'd0, 2'd1, 2'd0};
    for (int n = 0; n < 4; n++) begin
      step(vv[n], 4'hF, 1'b1, i, ov, rr, lk, lf);
      vectors++;
      if (i !== want[n]) begin
        miscompares++;
        $display("FAIL starvation[%0d]: got %0d expected %0d", n, i, want[n]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [1:0] i; logic ov; logic [3:0] rr; logic lk; logic [11:0] lf;
    step(4'b1000, 4'b0000, 1'b1, i, ov, rr, lk, lf);
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    req_eop   = 4'h0;
    out_ready = 1'b1;
    vectors++;
    if (locked !== 1'b1 || grant_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL midreset_pre: got lk=%b idx=%0d expected lk=1 idx=3", locked, grant_idx);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (locked !== 1'b0 || out_valid !== 1'b0 || req_ready !== 4'b0000 ||
        grant_onehot !== 4'b0000 || lfsr_value !== INIT) begin
      miscompares++;
      $display("FAIL midreset_async: got lk=%b ov=%b rr=%b oh=%b lfsr=%h expected 0/0/0000/0000/%h",
               locked, out_valid, req_ready, grant_onehot, lfsr_value, INIT);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    step(4'b1010, 4'hF, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (i !== 2'd3) begin
      miscompares++;
      $display("FAIL midreset_first_grant: got %0d expected 3", i);
    end
    step(4'b0011, 4'hF, 1'b1, i, ov, rr, lk, lf);
    vectors++;
    if (i !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_counter_clear: got %0d expected 0", i);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'h0;
    req_eop   = 4'h0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_random();
    test_packet_lock();
    test_owner_bubble();
    test_starvation();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
